ethernet_rx_frame_manager: RTL and testbench

ETHERNET_RX_FRAME_MANAGER -- requirements
Module: ethernet_rx_frame_manager

---
 rtl/ethernet_pkg.sv | 24 ++
 rtl/ethernet_rx_descriptor_fifo.sv | 49 ++++
 rtl/ethernet_rx_frame_manager.sv | 174 +++++++++++++++++
 tb/tb_ethernet_rx_frame_manager.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ethernet_pkg.sv
// Shared types and constants for the Ethernet receive frame manager.
package ethernet_pkg;

  localparam int unsigned FCS_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECEIVE,
    ST_WAIT_CHECK,
    ST_COMMIT,
    ST_DISCARD
  } rx_state_e;

  typedef struct packed {
    logic [10:0] length;
    logic [47:0] source;
    logic [15:0] length_type;
  } rx_desc_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ethernet_rx_descriptor_fifo.sv
// Synchronous descriptor FIFO with full/empty flags; push and pop may coincide.
module ethernet_rx_descriptor_fifo
  import ethernet_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = $bits(rx_desc_t)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_d    = wr_q + (AW+1)'(do_push);
    rd_d    = rd_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ethernet_rx_frame_manager.sv
// Receive frame manager: buffers frame bytes in a ring RAM, commits good frames
// (FCS stripped) as descriptors, and rolls back errored, runt or overflowing frames.
module ethernet_rx_frame_manager
  import ethernet_pkg::*;
#(
  parameter int unsigned BUFFER_BYTES = 2048,
  parameter int unsigned DESC_DEPTH   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_payload_i,
  input  logic        rx_payload_valid_i,
  input  logic        rx_packet_end_i,
  input  logic        rx_check_valid_i,
  input  logic        rx_packet_error_i,
  input  logic [47:0] rx_source_address_i,
  input  logic [15:0] rx_length_type_i,
  output logic        frame_valid_o,
  output logic [74:0] frame_desc_o,
  output logic [7:0]  data_o,
  input  logic        read_i,
  output logic [15:0] error_count_o,
  output logic [15:0] drop_count_o
);

  localparam int unsigned AW = $clog2(BUFFER_BYTES);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = $bits(rx_desc_t);

  logic [7:0]    mem_q [BUFFER_BYTES];
  rx_state_e     state_q, state_d;
  logic [PW-1:0] wr_q, wr_d, com_q, com_d, rd_q, rd_d, used;
  logic [10:0]   cnt_q, cnt_d, rd_cnt_q, rd_cnt_d, base_cnt;
  logic          ovf_q, ovf_d, err_q, err_d, fdrop_q, fdrop_d, skip_q, skip_d;
  logic [15:0]   err_cnt_q, err_cnt_d, drop_cnt_q, drop_cnt_d;
  logic          fifo_full, fifo_empty, push, pop, rd_fire, last_byte;
  logic          frame_start, accept, base_ovf, we;
  logic [DW-1:0] head_raw, push_raw;
  rx_desc_t      head, push_desc;

  assign used     = wr_q - rd_q;
  assign head     = head_raw;
  assign push_raw = push_desc;

  // A new frame restarts count/overflow from zero in the same cycle its first byte lands.
  always_comb begin
    frame_start = (state_q == ST_IDLE) && rx_payload_valid_i && !skip_q && !fifo_full;
    accept      = frame_start ||
                  (rx_payload_valid_i && (state_q == ST_RECEIVE || state_q == ST_WAIT_CHECK));
    base_ovf    = frame_start ? 1'b0 : ovf_q;
    base_cnt    = frame_start ? '0 : cnt_q;
    we          = accept && !base_ovf && (used != PW'(BUFFER_BYTES));
  end

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q + PW'(we);
    com_d      = com_q;
    cnt_d      = base_cnt + 11'(we);
    ovf_d      = base_ovf | (accept & ~we);
    err_d      = err_q;
    fdrop_d    = fdrop_q;
    skip_d     = skip_q & ~rx_packet_end_i;
    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;
    push       = 1'b0;
    push_desc  = '{length:      cnt_q - 11'(FCS_BYTES),
                   source:      rx_source_address_i,
                   length_type: rx_length_type_i};
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_RECEIVE;
          err_d   = 1'b0;
          fdrop_d = 1'b0;
        end else if (rx_payload_valid_i && !skip_q) begin
          // No descriptor slot: drop the frame and ignore its remaining bytes.
          state_d = ST_DISCARD;
          fdrop_d = 1'b1;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          skip_d  = ~rx_packet_end_i;
        end
      end
      ST_RECEIVE: begin
        if (rx_packet_end_i) state_d = ST_WAIT_CHECK;
      end
      ST_WAIT_CHECK: begin
        if (rx_check_valid_i) begin
          err_d   = rx_packet_error_i;
          state_d = (!rx_packet_error_i && !ovf_d && cnt_d > 11'(FCS_BYTES)) ? ST_COMMIT
                                                                              : ST_DISCARD;
        end
      end
      ST_COMMIT: begin
        push    = 1'b1;
        wr_d    = wr_q - PW'(FCS_BYTES);
        com_d   = wr_q - PW'(FCS_BYTES);
        state_d = ST_IDLE;
      end
      ST_DISCARD: begin
        wr_d = com_q;
        if (err_q) err_cnt_d = sat_inc(err_cnt_q);
        if (ovf_q || fdrop_q || cnt_q <= 11'(FCS_BYTES)) drop_cnt_d = sat_inc(drop_cnt_q);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_fire   = read_i && !fifo_empty;
    last_byte = (rd_cnt_q == head.length - 11'd1);
    pop       = rd_fire && last_byte;
    rd_d      = rd_q + PW'(rd_fire);
    rd_cnt_d  = rd_fire ? (last_byte ? '0 : rd_cnt_q + 11'd1) : rd_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_q       <= '0;
      com_q      <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      rd_cnt_q   <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      fdrop_q    <= 1'b0;
      skip_q     <= 1'b0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      com_q      <= com_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      fdrop_q    <= fdrop_d;
      skip_q     <= skip_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[wr_q[AW-1:0]] <= rx_payload_i;
  end

  ethernet_rx_descriptor_fifo #(
    .DEPTH (DESC_DEPTH),
    .WIDTH (DW)
  ) u_desc_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_raw),
    .pop_i   (pop),
    .data_o  (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign frame_valid_o = !fifo_empty;
  assign frame_desc_o  = head_raw;
  assign data_o        = mem_q[rd_q[AW-1:0]];
  assign error_count_o = err_cnt_q;
  assign drop_count_o  = drop_cnt_q;

endmodule

// File: tb/tb_ethernet_rx_frame_manager.sv
// Bench for ethernet_rx_frame_manager: frame-level reference model plus directed and random frames.
module tb_ethernet_rx_frame_manager;

  localparam int BUF        = 2048;
  localparam int DESC_DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_r, val_r, end_r, chk_r, err_r, rd_r, bg_rd, chk_en;
  logic [7:0]  pay_r;
  logic [47:0] src_r;
  logic [15:0] typ_r;
  logic        frame_valid_o;
  logic [74:0] frame_desc_o;
  logic [7:0]  data_o;
  logic [15:0] error_count_o, drop_count_o;

  always #5 clk = ~clk;

  ethernet_rx_frame_manager #(.BUFFER_BYTES(BUF), .DESC_DEPTH(DESC_DEPTH)) dut (
    .clk_i               (clk),
    .rst_i               (rst_r),
    .rx_payload_i        (pay_r),
    .rx_payload_valid_i  (val_r),
    .rx_packet_end_i     (end_r),
    .rx_check_valid_i    (chk_r),
    .rx_packet_error_i   (err_r),
    .rx_source_address_i (src_r),
    .rx_length_type_i    (typ_r),
    .frame_valid_o       (frame_valid_o),
    .frame_desc_o        (frame_desc_o),
    .data_o              (data_o),
    .read_i              (rd_r),
    .error_count_o       (error_count_o),
    .drop_count_o        (drop_count_o)
  );

  // Reference model: committed data as one byte stream plus a descriptor list.
  logic [7:0]  m_bytes[$];
  logic [74:0] m_desc[$];
  int          head_used;
  logic [15:0] m_err, m_drop;
  bit          p_valid, p_commit, p_err, p_drop;
  logic [74:0] p_desc;
  logic [7:0]  p_bytes[$];
  bit          f_active, f_ended, f_skip, f_ovf;
  logic [7:0]  f_bytes[$];

  always @(posedge clk) begin : ref_model
    int occ0, qsz0, n;
    bit ended_prev;
    if (rst_r) begin
      m_bytes.delete(); m_desc.delete(); p_bytes.delete(); f_bytes.delete();
      head_used = 0; p_valid = 0; f_active = 0; f_ended = 0; f_skip = 0; f_ovf = 0;
      m_err = '0; m_drop = '0;
    end else begin
      occ0 = m_bytes.size() + f_bytes.size() + ((p_valid && p_commit) ? p_bytes.size() : 0);
      qsz0 = m_desc.size();
      if (rd_r && qsz0 != 0) begin
        void'(m_bytes.pop_front());
        head_used++;
        if (head_used == int'(m_desc[0][74:64])) begin
          void'(m_desc.pop_front());
          head_used = 0;
        end
      end
      if (p_valid) begin
        if (p_commit) begin
          m_desc.push_back(p_desc);
          foreach (p_bytes[i]) m_bytes.push_back(p_bytes[i]);
        end else begin
          if (p_err && m_err != 16'hFFFF) m_err++;
          if (p_drop && m_drop != 16'hFFFF) m_drop++;
        end
        p_valid = 0;
        p_bytes.delete();
      end
      if (!f_active) begin
        if (val_r && !f_skip) begin
          if (qsz0 == DESC_DEPTH) begin
            p_valid = 1; p_commit = 0; p_err = 0; p_drop = 1; f_skip = 1;
          end else begin
            f_active = 1; f_ended = 0; f_ovf = 0;
            if (occ0 == BUF) f_ovf = 1; else f_bytes.push_back(pay_r);
          end
        end
        if (end_r) f_skip = 0;
      end else begin
        ended_prev = f_ended;
        if (val_r && !f_ovf) begin
          if (occ0 == BUF) f_ovf = 1; else f_bytes.push_back(pay_r);
        end
        if (end_r) f_ended = 1;
        if (ended_prev && chk_r) begin
          n = f_bytes.size() % BUF;
          p_valid = 1;
          if (!err_r && !f_ovf && n > 4) begin
            p_commit = 1;
            p_desc   = {11'(n - 4), src_r, typ_r};
            for (int i = 0; i < n - 4; i++) p_bytes.push_back(f_bytes[i]);
          end else begin
            p_commit = 0;
            p_err    = err_r;
            p_drop   = f_ovf || (n <= 4);
          end
          f_bytes.delete();
          f_active = 0;
        end
      end
    end
  end

  // Single checking process: per-cycle model compare plus queued literal expectations.
  typedef struct { string name; int sel; logic [63:0] exp; } lit_t;
  lit_t        lit_q[$];
  int          vectors = 0, miscompares = 0;
  logic [63:0] act_v, exp_v;

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      exp_v = 64'(m_desc.size() != 0);
      if (64'(frame_valid_o) !== exp_v) begin
        miscompares++;
        $display("FAIL frame_valid t=%0t: got %0h, required %0h", $time, frame_valid_o, exp_v);
      end
      if (m_desc.size() != 0) begin
        vectors++;
        if (frame_desc_o !== m_desc[0]) begin
          miscompares++;
          $display("FAIL frame_desc t=%0t: got %h, required %h", $time, frame_desc_o, m_desc[0]);
        end
        vectors++;
        if (m_bytes.size() == 0 || data_o !== m_bytes[0]) begin
          miscompares++;
          $display("FAIL data t=%0t: got %h, required %h", $time, data_o,
                   (m_bytes.size() != 0) ? m_bytes[0] : 8'hxx);
        end
      end
      vectors++;
      if (error_count_o !== m_err || drop_count_o !== m_drop) begin
        miscompares++;
        $display("FAIL counters t=%0t: got err=%0d drop=%0d, required err=%0d drop=%0d",
                 $time, error_count_o, drop_count_o, m_err, m_drop);
      end
      while (lit_q.size() != 0) begin
        lit_t l;
        l = lit_q.pop_front();
        case (l.sel)
          0:       act_v = 64'(frame_valid_o);
          1:       act_v = 64'(frame_desc_o[74:64]);
          2:       act_v = 64'(frame_desc_o[15:0]);
          3:       act_v = 64'(error_count_o);
          4:       act_v = 64'(drop_count_o);
          default: act_v = 64'(frame_desc_o[63:16]);
        endcase
        vectors++;
        if (act_v !== l.exp) begin
          miscompares++;
          $display("FAIL %s t=%0t: got %0h, required %0h", l.name, $time, act_v, l.exp);
        end
      end
    end
  end

  localparam int S_VALID = 0, S_LEN = 1, S_TYPE = 2, S_ERR = 3, S_DROP = 4, S_SRC = 5;

  task automatic lit(input string name, input int sel, input logic [63:0] exp);
    lit_t l;
    l.name = name; l.sel = sel; l.exp = exp;
    lit_q.push_back(l);
  endtask

  task automatic tick();
    if (bg_rd) rd_r = ($urandom_range(0, 2) == 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_r = 1'b1;
    tick(); tick();
    lit("reset_valid", S_VALID, 0);
    lit("reset_err", S_ERR, 0);
    lit("reset_drop", S_DROP, 0);
    rst_r = 1'b0;
    tick();
  endtask

  task automatic send_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) tick();
      pay_r = 8'($urandom);
      val_r = 1'b1; tick(); val_r = 1'b0;
    end
  endtask

  // Returns in the cycle after the check strobe was sampled (COMMIT or DISCARD cycle).
  task automatic send_frame(input int n, input bit err, input logic [47:0] src,
                            input logic [15:0] typ, input int glitch);
    tick();
    src_r = src; typ_r = typ;
    send_bytes(n);
    end_r = 1'b1; tick(); end_r = 1'b0;
    send_bytes(glitch);
    repeat ($urandom_range(0, 3)) tick();
    err_r = err; chk_r = 1'b1; tick(); chk_r = 1'b0; err_r = 1'b0;
  endtask

  task automatic read_n(input int n);
    rd_r = 1'b1;
    repeat (n) tick();
    rd_r = 1'b0;
  endtask

  task automatic read_all();
    int g = 0;
    rd_r = 1'b1;
    while (m_desc.size() != 0 && g < 4000) begin tick(); g++; end
    rd_r = 1'b0;
    lit("drained_valid", S_VALID, 0);
    tick();
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time budget exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_r = 1'b1; val_r = 0; end_r = 0; chk_r = 0; err_r = 0; rd_r = 0; bg_rd = 0;
    chk_en = 0; pay_r = '0; src_r = '0; typ_r = '0;
    @(posedge clk); #1;
    chk_en = 1;
    do_reset();

    // Good 64-byte frame: visible one cycle after COMMIT, 60 bytes after FCS strip.
    send_frame(64, 0, 48'h0011_2233_4455, 16'h0800, 0);
    lit("commit_cycle_valid", S_VALID, 0);
    tick();
    lit("t1_valid", S_VALID, 1);
    lit("t1_len", S_LEN, 60);
    lit("t1_type", S_TYPE, 16'h0800);
    lit("t1_src", S_SRC, 48'h0011_2233_4455);
    tick();
    read_n(60);
    lit("t1_after_read", S_VALID, 0);
    read_n(2);

    // FCS error: counted, no descriptor; full buffer must be free afterwards.
    do_reset();
    send_frame(100, 1, 48'hA, 16'h0806, 0);
    idle(3);
    lit("t2_err", S_ERR, 1);
    lit("t2_drop", S_DROP, 0);
    lit("t2_valid", S_VALID, 0);
    send_frame(2004, 0, 48'hB, 16'h86DD, 0);
    idle(2);
    lit("t2_big_len", S_LEN, 2000);
    read_all();

    // RAM overflow on the second frame; first frame must survive intact.
    do_reset();
    send_frame(1004, 0, 48'hC, 16'h0800, 0);
    send_frame(1100, 0, 48'hD, 16'h0800, 0);
    idle(3);
    lit("t3_drop", S_DROP, 1);
    lit("t3_err", S_ERR, 0);
    lit("t3_len", S_LEN, 1000);
    read_all();

    // Nine frames without reads: ninth has no descriptor slot.
    do_reset();
    for (int i = 0; i < 9; i++) send_frame(20, 0, 48'(i), 16'(16'h100 + i), 0);
    idle(3);
    lit("t4_drop", S_DROP, 1);
    lit("t4_len", S_LEN, 16);
    read_all();

    // Runt, then reset in the middle of a frame, then a normal frame.
    do_reset();
    send_frame(3, 0, 48'hE, 16'h0800, 0);
    idle(3);
    lit("t5_runt_drop", S_DROP, 1);
    tick();
    src_r = 48'hF;
    send_bytes(30);
    do_reset();
    send_frame(50, 0, 48'h10, 16'h0800, 1);
    idle(2);
    lit("t5_len", S_LEN, 47);
    read_all();

    // Last-byte read of frame A coincides with COMMIT of frame B.
    do_reset();
    send_frame(40, 0, 48'h20, 16'h1111, 0);
    idle(2);
    read_n(35);
    send_frame(30, 0, 48'h21, 16'h2222, 0);
    rd_r = 1'b1; tick(); rd_r = 1'b0;
    lit("t6_valid", S_VALID, 1);
    lit("t6_len", S_LEN, 26);
    lit("t6_type", S_TYPE, 16'h2222);
    tick();
    read_all();

    // Random frames with background reads, errors, runts and carrier glitches.
    do_reset();
    bg_rd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_frame($urandom_range(1, 300), ($urandom_range(0, 5) == 0),
                 {16'h0, 32'($urandom)}, 16'($urandom),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
    end
    idle(4);
    bg_rd = 1'b0;
    rd_r  = 1'b0;
    read_all();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
